// File: rtl/apb4_slave_if_ws.sv
// APB4 slave front-end: setup capture, one-cycle register strobe, fixed wait states, DONE with pready.
// Define APB4_SLV_PROT_EN to make unprivileged writes (pprot[0]=0) illegal.
module apb4_slave_if_ws #(
    parameter int ADDRWIDTH   = 12,
    parameter int DATAWIDTH   = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int REG_SPAN    = 4096
) (
    input  logic                   pclk,
    input  logic                   presetn,
    input  logic                   psel,
    input  logic [ADDRWIDTH-1:0]   paddr,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [DATAWIDTH-1:0]   pwdata,
    input  logic [DATAWIDTH/8-1:0] pstrb,
    input  logic [2:0]             pprot,
    output logic [DATAWIDTH-1:0]   prdata,
    output logic                   pready,
    output logic                   pslverr,
    output logic [ADDRWIDTH-1:0]   addr,
    output logic                   read_en,
    output logic                   write_en,
    output logic [DATAWIDTH/8-1:0] byte_strobe,
    output logic [DATAWIDTH-1:0]   wdata,
    input  logic [DATAWIDTH-1:0]   rdata,
    input  logic                   reg_err
);

    localparam int STRBW = DATAWIDTH / 8;
    localparam logic [ADDRWIDTH-1:0] ALIGN_MASK = ADDRWIDTH'(STRBW - 1);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

    state_t               state, state_nxt;
    logic [3:0]           cnt;
    logic [ADDRWIDTH-1:0] addr_q;
    logic                 write_q;
    logic [DATAWIDTH-1:0] wdata_q;
    logic [STRBW-1:0]     strb_q;
    logic [2:0]           prot_q;
    logic [DATAWIDTH-1:0] rdata_q;
    logic                 err_q;
    logic                 setup;
    logic                 illegal;
    logic                 strobe;
    logic                 unused_prot;

    assign setup = psel && !penable;

    // Decode works on the captured request so late paddr changes cannot affect it.
    always_comb begin
        illegal = (64'(addr_q) >= 64'(REG_SPAN)) || ((addr_q & ALIGN_MASK) != '0);
`ifdef APB4_SLV_PROT_EN
        if (write_q && !prot_q[0])
            illegal = 1'b1;
`endif
    end
    assign unused_prot = ^prot_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == STROBE)
                cnt <= CNT_INIT;
            else if (state == WAIT)
                cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (setup) state_nxt = STROBE;
            STROBE:  if (!psel) state_nxt = IDLE;
                     else if (WAIT_CYCLES == 1) state_nxt = DONE;
                     else state_nxt = WAIT;
            WAIT:    if (!psel) state_nxt = IDLE;
                     else if (cnt == 4'd1) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && setup) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
                prot_q  <= pprot;
            end
            if (state == STROBE) begin
                rdata_q <= rdata;
                err_q   <= strobe & reg_err;
            end
        end
    end

    // An abort in the strobe cycle suppresses the strobe.
    assign strobe      = (state == STROBE) && psel && !illegal;
    assign read_en     = strobe && !write_q;
    assign write_en    = strobe && write_q;
    assign addr        = (state == STROBE) ? addr_q : '0;
    assign wdata       = (state == STROBE && write_q) ? wdata_q : '0;
    assign byte_strobe = (state == STROBE && write_q) ? strb_q : '0;

    assign pready  = (state == DONE);
    assign prdata  = (state == DONE && !illegal && !write_q) ? rdata_q : '0;
    assign pslverr = (state == DONE) && (illegal || err_q);

endmodule

// File: tb/tb_apb4_slave_if_ws.sv
// Directed + randomized bench for apb4_slave_if_ws against a transaction-level expectation model.
module tb_apb4_slave_if_ws;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int WC   = 3;
    localparam int SPAN = 2048;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;
    logic [AW-1:0] addr;
    logic          read_en, write_en;
    logic [3:0]    byte_strobe;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          reg_err;

    int n_pass  = 0;
    int n_total = 0;

    apb4_slave_if_ws #(
        .ADDRWIDTH(AW), .DATAWIDTH(DW), .WAIT_CYCLES(WC), .REG_SPAN(SPAN)
    ) dut (
        .pclk(pclk), .presetn(presetn), .psel(psel), .paddr(paddr), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr), .addr(addr),
        .read_en(read_en), .write_en(write_en), .byte_strobe(byte_strobe),
        .wdata(wdata), .rdata(rdata), .reg_err(reg_err)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference rules: in-range, word-aligned, and (with protection) privileged for writes.
    function automatic bit exp_legal(input bit wr, input logic [AW-1:0] a, input logic [2:0] pr);
        bit ok;
        ok = (int'(a) < SPAN) && (int'(a) % (DW / 8) == 0);
`ifdef APB4_SLV_PROT_EN
        if (wr && !pr[0]) ok = 1'b0;
`endif
        return ok;
    endfunction

    task automatic quiet_all(input string tag);
        chk(tag, 32'(|prdata | pready | pslverr | read_en | write_en | (|addr) | (|byte_strobe) | (|wdata)), 32'd0);
    endtask

    task automatic idle(input int n, input bit drop);
        int act;
        act = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge pclk);
            if (drop) psel = 1'b0;
            #1;
            if (read_en || write_en || pready) act++;
        end
        chk("idle_quiet", 32'(act), 32'd0);
    endtask

    // One transfer: setup cycle, then access cycles until pready (or abort window elapses).
    task automatic do_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [3:0] s, input logic [2:0] pr,
                           input logic [DW-1:0] rd_val, input bit rerr, input int abort_at);
        int rd_cnt, wr_cnt, strobe_cyc, rdy_cyc, stray;
        bit legal;
        int exp_str;
        logic [DW-1:0] got_prdata;
        logic got_err;
        rd_cnt = 0; wr_cnt = 0; strobe_cyc = 0; rdy_cyc = 0; stray = 0;
        got_prdata = '0; got_err = 1'b0;
        legal = exp_legal(wr, a, pr);
        exp_str = (legal && (abort_at == 0 || abort_at > 1)) ? 1 : 0;

        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = pr;
        rdata = $urandom; reg_err = 1'b0;
        for (int k = 1; k <= WC + 3 && rdy_cyc == 0; k++) begin
            @(negedge pclk);
            penable = 1'b1;
            paddr = AW'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
            pprot = 3'($urandom); pwrite = 1'($urandom);
            rdata = (k == 1) ? rd_val : $urandom;
            reg_err = (k == 1) ? rerr : 1'($urandom);
            if (abort_at != 0 && k >= abort_at) psel = 1'b0;
            #1;
            if (read_en || write_en) begin
                strobe_cyc = k;
                if (read_en) rd_cnt++;
                if (write_en) wr_cnt++;
                chk("strobe_addr", 32'(addr), 32'(a));
                chk("strobe_bs", 32'(byte_strobe), wr ? 32'(s) : 32'd0);
                if (wr) chk("strobe_wdata", wdata, d);
            end
            if (pready) begin
                rdy_cyc = k;
                got_prdata = prdata;
                got_err = pslverr;
            end else if (prdata !== '0 || pslverr !== 1'b0) begin
                stray++;
            end
        end

        chk("strobe_count", 32'(rd_cnt + wr_cnt), 32'(exp_str));
        if (exp_str == 1) begin
            chk("strobe_kind", 32'(wr_cnt), wr ? 32'd1 : 32'd0);
            chk("strobe_cycle", 32'(strobe_cyc), 32'd1);
        end
        chk("no_stray_resp", 32'(stray), 32'd0);
        if (abort_at != 0) begin
            chk("abort_no_ready", 32'(rdy_cyc), 32'd0);
        end else begin
            chk("ready_cycle", 32'(rdy_cyc), 32'(WC + 1));
            chk("prdata", got_prdata, (legal && !wr) ? rd_val : 32'd0);
            chk("pslverr", 32'(got_err), 32'(!legal || rerr));
        end
    endtask

    task automatic rst_mid(input int k);
        int act;
        act = 0;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020;
        pwdata = $urandom | 32'h1; pstrb = 4'hF; pprot = 3'b001;
        for (int c = 1; c <= k; c++) begin
            @(negedge pclk);
            penable = 1'b1;
        end
        #1;
        if (k == 1) chk("rst_pre_strobe", 32'(write_en), 32'd1);
        presetn = 1'b0;
        #1;
        quiet_all("rst_async_outs");
        @(negedge pclk);
        presetn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge pclk);
            #1;
            if (read_en || write_en || pready) act++;
        end
        chk("rst_no_resume", 32'(act), 32'd0);
        psel = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        bit wr;
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0; rdata = '0; reg_err = 1'b0;
        repeat (3) @(negedge pclk);
        psel = 1'b1; rdata = 32'hFFFF_FFFF;
        #1;
        quiet_all("reset_outs");
        @(negedge pclk);
        #1;
        quiet_all("reset_outs_held");
        presetn = 1'b1; psel = 1'b0;
        idle(2, 1'b1);

        // Stray penable without setup
        @(negedge pclk);
        psel = 1'b1; penable = 1'b1;
        idle(3, 1'b0);
        psel = 1'b0; penable = 1'b0;

        do_xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 3'b001, 32'h0, 1'b0, 0);
        idle(1, 1'b1);
        do_xfer(1'b0, 12'h010, 32'h0, 4'hF, 3'b001, 32'h12345678, 1'b0, 0);
        idle(1, 1'b1);
        do_xfer(1'b0, 12'h002, 32'h0, 4'hF, 3'b001, 32'hA5A5A5A5, 1'b0, 0);
        do_xfer(1'b0, 12'(SPAN), 32'h0, 4'hF, 3'b001, 32'h5A5A5A5A, 1'b0, 0);
        do_xfer(1'b1, 12'h7FC, 32'h01020304, 4'h5, 3'b001, 32'h0, 1'b1, 0);
        idle(2, 1'b0);

        // Back-to-back writes, then a third aborted in WAIT
        do_xfer(1'b1, 12'h100, 32'h11111111, 4'hF, 3'b011, 32'h0, 1'b0, 0);
        do_xfer(1'b1, 12'h104, 32'h22222222, 4'h3, 3'b001, 32'h0, 1'b0, 0);
        do_xfer(1'b1, 12'h108, 32'h33333333, 4'hF, 3'b001, 32'h0, 1'b0, 2);
        do_xfer(1'b0, 12'h108, 32'h0, 4'hF, 3'b000, 32'h0BADF00D, 1'b0, 0);

        do_xfer(1'b1, 12'h040, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0, 1'b0, 0);
        idle(1, 1'b1);

        rst_mid(1);
        rst_mid(2);
        do_xfer(1'b0, 12'h020, 32'h0, 4'hF, 3'b001, 32'h600DCAFE, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom);
            case ($urandom_range(0, 3))
                0, 1:    a = AW'($urandom_range(0, SPAN / 4 - 1) * 4);
                2:       a = AW'($urandom_range(0, SPAN - 1)) | 12'h1;
                default: a = AW'($urandom_range(SPAN, 4095));
            endcase
            do_xfer(wr, a, $urandom, 4'($urandom), 3'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0) ? 2 : 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
